// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the three-core memory arbiter.
// Holds the default word/address widths, the fixed port count, the FSM state
// encoding and the operation-select helper used when a RAM access is issued.
package mem_arbiter_pkg;

   localparam int unsigned DATA_LEN    = 16;
   localparam int unsigned ADDRESS_LEN = 8;
   localparam int unsigned NUM_PORTS   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Result of choosing which pending operation goes to the RAM next
   typedef struct packed {
      logic                 op_write;
      logic                 mixed;
      logic [NUM_PORTS-1:0] served;
   } issue_sel_t;

   // Reads and writes never share one access; prio breaks ties on mixed sets
   function automatic issue_sel_t select_op(input logic [NUM_PORTS-1:0] pend,
                                            input logic [NUM_PORTS-1:0] we,
                                            input logic                 prio);
      logic [NUM_PORTS-1:0] rd;
      logic [NUM_PORTS-1:0] wr;
      issue_sel_t           sel;
      rd           = pend & ~we;
      wr           = pend & we;
      sel.mixed    = (|rd) && (|wr);
      sel.op_write = sel.mixed ? prio : (|wr);
      sel.served   = sel.op_write ? wr : rd;
      return sel;
   endfunction

endpackage : mem_arbiter_pkg

// File: rtl/mem_arb_lane_pack.sv
// Served-mask lane packing for the RAM address and write-data buses.
// Served lanes pass their own address/data; unserved lanes copy the
// lowest-index served lane so every RAM lane carries a harmless duplicate
// (a redundant write of the same value, or a redundant read).
//   served   : lanes taking part in the access
//   addr_in  : lane-packed core addresses
//   wdata_in : lane-packed core write data
//   addr_out : lane-packed RAM addresses
//   data_out : lane-packed RAM write data
module mem_arb_lane_pack #(
   parameter int unsigned DATA_LEN    = mem_arbiter_pkg::DATA_LEN,
   parameter int unsigned ADDRESS_LEN = mem_arbiter_pkg::ADDRESS_LEN
) (
   input  logic [mem_arbiter_pkg::NUM_PORTS-1:0]             served,
   input  logic [mem_arbiter_pkg::NUM_PORTS*ADDRESS_LEN-1:0] addr_in,
   input  logic [mem_arbiter_pkg::NUM_PORTS*DATA_LEN-1:0]    wdata_in,
   output logic [mem_arbiter_pkg::NUM_PORTS*ADDRESS_LEN-1:0] addr_out,
   output logic [mem_arbiter_pkg::NUM_PORTS*DATA_LEN-1:0]    data_out
);
   import mem_arbiter_pkg::*;

   int unsigned low;
   logic        found;

   // Lowest-index served lane is the fill source
   always_comb begin
      low   = 0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (served[i] && !found) begin
            low   = i;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      addr_out = '0;
      data_out = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (served[i]) begin
            addr_out[i*ADDRESS_LEN +: ADDRESS_LEN] = addr_in[i*ADDRESS_LEN +: ADDRESS_LEN];
            data_out[i*DATA_LEN +: DATA_LEN]       = wdata_in[i*DATA_LEN +: DATA_LEN];
         end else begin
            addr_out[i*ADDRESS_LEN +: ADDRESS_LEN] = addr_in[low*ADDRESS_LEN +: ADDRESS_LEN];
            data_out[i*DATA_LEN +: DATA_LEN]       = wdata_in[low*DATA_LEN +: DATA_LEN];
         end
      end
   end

endmodule : mem_arb_lane_pack

// File: rtl/mem_arbiter.sv
// Three-core memory arbiter: batches concurrent requests into single RAM
// accesses (all pending reads together, or all pending writes together).
//   clk, rst      : clock, synchronous active-high reset
//   req/we        : per-core request (held until ack) and write(1)/read(0)
//   addr/wdata    : per-core lane-packed address and write data
//   ack           : per-core one-cycle completion pulse
//   rdata         : per-core lane-packed read data, held until next read
//   ram_read/ram_write         : RAM strobes, never both high
//   ram_address/ram_data_in    : lane-packed RAM address and write data
//   ram_data_out  : lane-packed RAM read data, one cycle after ram_read
module mem_arbiter #(
   parameter int unsigned DATA_LEN    = mem_arbiter_pkg::DATA_LEN,
   parameter int unsigned ADDRESS_LEN = mem_arbiter_pkg::ADDRESS_LEN
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic [mem_arbiter_pkg::NUM_PORTS-1:0]             req,
   input  logic [mem_arbiter_pkg::NUM_PORTS-1:0]             we,
   input  logic [mem_arbiter_pkg::NUM_PORTS*ADDRESS_LEN-1:0] addr,
   input  logic [mem_arbiter_pkg::NUM_PORTS*DATA_LEN-1:0]    wdata,
   output logic [mem_arbiter_pkg::NUM_PORTS-1:0]             ack,
   output logic [mem_arbiter_pkg::NUM_PORTS*DATA_LEN-1:0]    rdata,
   output logic                                              ram_read,
   output logic                                              ram_write,
   output logic [mem_arbiter_pkg::NUM_PORTS*ADDRESS_LEN-1:0] ram_address,
   output logic [mem_arbiter_pkg::NUM_PORTS*DATA_LEN-1:0]    ram_data_in,
   input  logic [mem_arbiter_pkg::NUM_PORTS*DATA_LEN-1:0]    ram_data_out
);
   import mem_arbiter_pkg::*;

   localparam int unsigned NP = NUM_PORTS;
   localparam int unsigned AW = NP * ADDRESS_LEN;
   localparam int unsigned DW = NP * DATA_LEN;

   state_t        state;
   logic [NP-1:0] pend_q;
   logic [NP-1:0] pend_we_q;
   logic [AW-1:0] pend_addr_q;
   logic [DW-1:0] pend_wdata_q;
   logic [NP-1:0] served_q;
   logic          op_write_q;
   logic          prio_q;
   logic          ram_read_q;
   logic          ram_write_q;

   logic [NP-1:0] cap;
   logic [NP-1:0] remain;
   logic [NP-1:0] sel_pend;
   logic [NP-1:0] sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   issue_sel_t    sel;
   logic          start_issue;
   logic [AW-1:0] pack_addr;
   logic [DW-1:0] pack_data;

   // A core still high in its own ack cycle is not recaptured
   assign cap    = req & ~ack;
   assign remain = pend_q & ~served_q;

   // Candidate set for the next access: fresh captures in IDLE, leftovers in RESP
   always_comb begin
      sel_pend  = remain;
      sel_we    = pend_we_q;
      sel_addr  = pend_addr_q;
      sel_wdata = pend_wdata_q;
      if (state == IDLE) begin
         sel_pend  = cap;
         sel_we    = we;
         sel_addr  = addr;
         sel_wdata = wdata;
      end
   end

   assign sel         = select_op(sel_pend, sel_we, prio_q);
   assign start_issue = ((state == IDLE) && (|cap)) || ((state == RESP) && (|remain));

   mem_arb_lane_pack #(
      .DATA_LEN    (DATA_LEN),
      .ADDRESS_LEN (ADDRESS_LEN)
   ) u_lane_pack (
      .served   (sel.served),
      .addr_in  (sel_addr),
      .wdata_in (sel_wdata),
      .addr_out (pack_addr),
      .data_out (pack_data)
   );

   // Arbiter FSM with registered strobes, RAM buses, acks and read data
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         pend_q       <= '0;
         pend_we_q    <= '0;
         pend_addr_q  <= '0;
         pend_wdata_q <= '0;
         served_q     <= '0;
         op_write_q   <= 1'b0;
         prio_q       <= 1'b0;
         ram_read_q   <= 1'b0;
         ram_write_q  <= 1'b0;
         ram_address  <= '0;
         ram_data_in  <= '0;
         ack          <= '0;
         rdata        <= '0;
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               pend_q <= cap;
               for (int unsigned i = 0; i < NP; i++) begin
                  if (cap[i]) begin
                     pend_we_q[i]                              <= we[i];
                     pend_addr_q[i*ADDRESS_LEN +: ADDRESS_LEN] <= addr[i*ADDRESS_LEN +: ADDRESS_LEN];
                     pend_wdata_q[i*DATA_LEN +: DATA_LEN]      <= wdata[i*DATA_LEN +: DATA_LEN];
                  end
               end
               if (|cap) state <= ISSUE;
            end
            ISSUE: begin
               ram_read_q  <= 1'b0;
               ram_write_q <= 1'b0;
               state       <= RESP;
            end
            RESP: begin
               ack    <= served_q;
               pend_q <= remain;
               for (int unsigned i = 0; i < NP; i++) begin
                  if (served_q[i] && !op_write_q)
                     rdata[i*DATA_LEN +: DATA_LEN] <= ram_data_out[i*DATA_LEN +: DATA_LEN];
               end
               state <= (|remain) ? ISSUE : IDLE;
            end
            default: state <= IDLE;
         endcase

         // Launch a RAM access so the strobe is high for the whole ISSUE cycle
         if (start_issue) begin
            served_q    <= sel.served;
            op_write_q  <= sel.op_write;
            ram_read_q  <= ~sel.op_write;
            ram_write_q <= sel.op_write;
            ram_address <= pack_addr;
            ram_data_in <= pack_data;
            if (sel.mixed) prio_q <= ~prio_q;
         end
      end
   end

   assign ram_read  = ram_read_q;
   // Reset aborts an in-flight write within the same cycle
   assign ram_write = ram_write_q & ~rst;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a three-lane RAM model.
module tb_mem_arbiter;

   localparam int unsigned DL = 16;
   localparam int unsigned AL = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    req;
   logic [2:0]    we;
   logic [3*AL-1:0] addr;
   logic [3*DL-1:0] wdata;
   logic [2:0]    ack;
   logic [3*DL-1:0] rdata;
   logic          ram_read;
   logic          ram_write;
   logic [3*AL-1:0] ram_address;
   logic [3*DL-1:0] ram_data_in;
   logic [3*DL-1:0] ram_data_out;

   logic [DL-1:0] mem [256];
   int            rd_pulses = 0;
   int            n_cmp = 0;
   int            n_err = 0;
   int            rd_start;

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_LEN(DL), .ADDRESS_LEN(AL)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .we           (we),
      .addr         (addr),
      .wdata        (wdata),
      .ack          (ack),
      .rdata        (rdata),
      .ram_read     (ram_read),
      .ram_write    (ram_write),
      .ram_address  (ram_address),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out)
   );

   // RAM model: lanes written in ascending order, so the highest lane wins
   always @(posedge clk) begin
      if (ram_write) begin
         for (int i = 0; i < 3; i++)
            mem[ram_address[i*AL +: AL]] <= ram_data_in[i*DL +: DL];
      end
      if (ram_read) begin
         for (int i = 0; i < 3; i++)
            ram_data_out[i*DL +: DL] <= mem[ram_address[i*AL +: AL]];
         rd_pulses <= rd_pulses + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req   = 3'b000;
      we    = 3'b000;
      addr  = '0;
      wdata = '0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[62] = 16'd10;
      mem[63] = 16'd2;
      mem[64] = 16'd1;
      ram_data_out = '0;
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      check("reset_ack", 64'(ack), 64'd0);
      check("reset_rdata", 64'(rdata), 64'd0);
      check("reset_ram_read", 64'(ram_read), 64'd0);
      check("reset_ram_write", 64'(ram_write), 64'd0);
      rst = 1'b0;
      tick();

      // Single read: core0 reads 62, ack held req must not be recaptured
      req = 3'b001; we = 3'b000; addr = {8'd0, 8'd0, 8'd62};
      tick();
      check("single_issue_read", 64'(ram_read), 64'd1);
      check("single_issue_addr", 64'(ram_address[7:0]), 64'd62);
      tick();
      check("single_resp_ack", 64'(ack), 64'd0);
      check("single_resp_strobe", 64'(ram_read), 64'd0);
      tick();
      check("single_ack", 64'(ack), 64'b001);
      check("single_rdata", 64'(rdata[15:0]), 64'd10);
      tick();
      check("single_ack_drop", 64'(ack), 64'd0);
      check("single_no_recapture", 64'(ram_read), 64'd0);
      idle_inputs();
      tick();

      // Batched read of 62/63/64 in one RAM access
      rd_start = rd_pulses;
      req = 3'b111; we = 3'b000; addr = {8'd64, 8'd63, 8'd62};
      tick();
      check("batch_issue_read", 64'(ram_read), 64'd1);
      tick();
      tick();
      check("batch_ack", 64'(ack), 64'b111);
      check("batch_rdata", 64'(rdata), {16'd0, 16'd1, 16'd2, 16'd10});
      check("batch_one_pulse", 64'(rd_pulses - rd_start), 64'd1);
      idle_inputs();
      tick();
      tick();

      // Mixed batch with prio=0: read of 114 first, then write 0x55AA
      req = 3'b011; we = 3'b001; addr = {8'd0, 8'd114, 8'd114};
      wdata = {16'd0, 16'd0, 16'h55AA};
      tick();
      check("mixed1_read_first", 64'({ram_read, ram_write}), 64'b10);
      tick();
      tick();
      check("mixed1_read_ack", 64'(ack), 64'b010);
      check("mixed1_rdata", 64'(rdata[31:16]), 64'd0);
      check("mixed1_write_issue", 64'({ram_read, ram_write}), 64'b01);
      req = 3'b001;
      tick();
      check("mixed1_resp_ack", 64'(ack), 64'd0);
      tick();
      check("mixed1_write_ack", 64'(ack), 64'b001);
      check("mixed1_mem114", 64'(mem[114]), 64'h55AA);
      idle_inputs();
      tick();
      tick();

      // Mixed batch with prio=1: write goes first this time
      req = 3'b101; we = 3'b100; addr = {8'd120, 8'd0, 8'd114};
      wdata = {16'hBEEF, 16'd0, 16'd0};
      tick();
      check("mixed2_write_first", 64'({ram_read, ram_write}), 64'b01);
      tick();
      tick();
      check("mixed2_write_ack", 64'(ack), 64'b100);
      req = 3'b001;
      tick();
      tick();
      check("mixed2_read_ack", 64'(ack), 64'b001);
      check("mixed2_rdata", 64'(rdata[15:0]), 64'h55AA);
      check("mixed2_mem120", 64'(mem[120]), 64'hBEEF);
      idle_inputs();
      tick();
      tick();

      // Write conflict on 115: core2 data must land
      req = 3'b101; we = 3'b101; addr = {8'd115, 8'd0, 8'd115};
      wdata = {16'h2222, 16'd0, 16'h1111};
      tick();
      tick();
      tick();
      check("conflict_ack", 64'(ack), 64'b101);
      idle_inputs();
      tick();
      tick();
      req = 3'b001; we = 3'b000; addr = {8'd0, 8'd0, 8'd115};
      tick();
      tick();
      tick();
      check("conflict_read_ack", 64'(ack), 64'b001);
      check("conflict_rdata", 64'(rdata[15:0]), 64'h2222);
      idle_inputs();
      tick();
      tick();

      // Lone write from core1: unserved lanes duplicate lane1
      req = 3'b010; we = 3'b010; addr = {8'd118, 8'd116, 8'd117};
      wdata = {16'd9, 16'd7, 16'd8};
      tick();
      check("fill_addr", 64'(ram_address), {40'd0, 8'd116, 8'd116, 8'd116});
      check("fill_data", 64'(ram_data_in), {16'd0, 16'd7, 16'd7, 16'd7});
      tick();
      tick();
      check("fill_ack", 64'(ack), 64'b010);
      check("fill_mem116", 64'(mem[116]), 64'd7);
      check("fill_mem117", 64'(mem[117]), 64'd0);
      check("fill_mem118", 64'(mem[118]), 64'd0);
      idle_inputs();
      tick();
      tick();

      // Reset while a write to 119 is in ISSUE
      req = 3'b001; we = 3'b001; addr = {8'd0, 8'd0, 8'd119};
      wdata = {16'd0, 16'd0, 16'hABCD};
      tick();
      check("abort_issue_write", 64'(ram_write), 64'd1);
      rst = 1'b1;
      #1;
      check("abort_write_gated", 64'(ram_write), 64'd0);
      tick();
      rst = 1'b0;
      idle_inputs();
      #1;
      check("abort_ack", 64'(ack), 64'd0);
      check("abort_strobes", 64'({ram_read, ram_write}), 64'd0);
      check("abort_rdata", 64'(rdata), 64'd0);
      tick();
      tick();
      tick();
      check("abort_no_late_ack", 64'(ack), 64'd0);
      check("abort_mem119", 64'(mem[119]), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mem_arbiter
